// File: rtl/iob_cfg_pkg.sv
// Shared types and constants for the IO block configuration loader.
package iob_cfg_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } cfg_state_e;

  localparam int unsigned BITS_PER_IOB = 3;
  localparam int unsigned SYNC_W       = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 8'hA5;

  // TSMUX encodings as seen by an IO block; any code with bit 1 set always drives OUT.
  localparam logic [1:0] TSMUX_HIZ   = 2'b00;
  localparam logic [1:0] TSMUX_TS    = 2'b01;
  localparam logic [1:0] TSMUX_DRIVE = 2'b10;

endpackage

// File: rtl/iob_cfg_sync_det.sv
// Frame sync detector: tracks the recent valid bits and flags the sync word.
module iob_cfg_sync_det
  import iob_cfg_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic din_i,
  input  logic clr_i,
  output logic sync_hit_c
);

  // The oldest window bit is shifted out on every compare, so only the
  // newest SYNC_W-1 bits are stored; the incoming bit completes the window.
  logic [SYNC_W-2:0] hist_q;
  logic [SYNC_W-2:0] hist_d;

  // Compare the would-be window against the sync word and compute the next history.
  always_comb begin
    hist_d     = hist_q;
    sync_hit_c = en_i && ({hist_q, din_i} == SYNC_WORD);
    if (clr_i) begin
      hist_d = '0;
    end else if (en_i) begin
      hist_d = {hist_q[SYNC_W-3:0], din_i};
    end
  end

  // History register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/ioblock_cfg_loader.sv
// Serial configuration writer for the IO block array: hunts for sync, stages
// the payload, and commits TSMUX/DORREG atomically on a good parity bit.
module ioblock_cfg_loader
  import iob_cfg_pkg::*;
#(
  parameter int unsigned       NUM_IOB   = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                 IOCLK,
  input  logic                 RST,
  input  logic                 CFG_EN,
  input  logic                 CFG_DIN,
  output logic [2*NUM_IOB-1:0] TSMUX_CFG,
  output logic [NUM_IOB-1:0]   DORREG_CFG,
  output logic                 CFG_BUSY,
  output logic                 CFG_DONE,
  output logic                 CFG_ERR
);

  localparam int unsigned PAY_W = BITS_PER_IOB * NUM_IOB;
  localparam int unsigned CNT_W = (PAY_W > 1) ? $clog2(PAY_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAY_W - 1);

  cfg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic [PAY_W-1:0]     stg_q, stg_d;
  logic [2*NUM_IOB-1:0] tsmux_q, tsmux_d;
  logic [NUM_IOB-1:0]   dor_q, dor_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [2*NUM_IOB-1:0] stg_tsmux;
  logic [NUM_IOB-1:0]   stg_dor;
  logic                 hunt_en;
  logic                 sync_hit_c;

  assign hunt_en = CFG_EN && (state_q == HUNT);

  iob_cfg_sync_det #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .clk_i      (IOCLK),
    .rst_i      (RST),
    .en_i       (hunt_en),
    .din_i      (CFG_DIN),
    .clr_i      (sync_hit_c),
    .sync_hit_c (sync_hit_c)
  );

  // Unpack staging (stream order TSMUX[1], TSMUX[0], DORREG per block) into output layout.
  always_comb begin
    stg_tsmux = '0;
    stg_dor   = '0;
    for (int i = 0; i < int'(NUM_IOB); i++) begin
      stg_tsmux[2*i+1] = stg_q[BITS_PER_IOB*i];
      stg_tsmux[2*i]   = stg_q[BITS_PER_IOB*i+1];
      stg_dor[i]       = stg_q[BITS_PER_IOB*i+2];
    end
  end

  // Next-state and output logic for the hunt/load/check sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    stg_d   = stg_q;
    tsmux_d = tsmux_q;
    dor_d   = dor_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      HUNT: begin
        if (sync_hit_c) begin
          state_d = LOAD;
          cnt_d   = '0;
          par_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (CFG_EN) begin
          stg_d[cnt_q] = CFG_DIN;
          par_d        = par_q ^ CFG_DIN;
          if (cnt_q == CNT_LAST) begin
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (CFG_EN) begin
          state_d = HUNT;
          busy_d  = 1'b0;
          if (!(par_q ^ CFG_DIN)) begin
            tsmux_d = stg_tsmux;
            dor_d   = stg_dor;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = HUNT;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      stg_q   <= '0;
      tsmux_q <= {NUM_IOB{TSMUX_HIZ}};
      dor_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      stg_q   <= stg_d;
      tsmux_q <= tsmux_d;
      dor_q   <= dor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign TSMUX_CFG  = tsmux_q;
  assign DORREG_CFG = dor_q;
  assign CFG_BUSY   = busy_q;
  assign CFG_DONE   = done_q;
  assign CFG_ERR    = err_q;

endmodule

// File: tb/tb_ioblock_cfg_loader.sv
// Scoreboard bench for ioblock_cfg_loader with two IO blocks.
module tb_ioblock_cfg_loader;
  import iob_cfg_pkg::*;

  localparam int unsigned N = 2;

  logic           IOCLK = 1'b0;
  logic           RST;
  logic           CFG_EN;
  logic           CFG_DIN;
  logic [2*N-1:0] TSMUX_CFG;
  logic [N-1:0]   DORREG_CFG;
  logic           CFG_BUSY;
  logic           CFG_DONE;
  logic           CFG_ERR;

  typedef struct packed {
    logic [3:0] ts;
    logic [1:0] dor;
    logic       done;
    logic       err;
  } exp_t;

  // Payloads are sent from bit 5 down to bit 0.
  localparam logic [5:0] PAY_A = 6'b011100;
  localparam logic [5:0] PAY_B = 6'b110001;
  localparam exp_t EXP_A     = {TSMUX_DRIVE, TSMUX_TS, 2'b01, 1'b1, 1'b0};
  localparam exp_t EXP_A_BAD = {TSMUX_DRIVE, TSMUX_TS, 2'b01, 1'b0, 1'b1};
  localparam exp_t EXP_B     = {2'b00, 2'b11, 2'b10, 1'b1, 1'b0};
  localparam exp_t EXP_RST   = {4'b0000, 2'b00, 1'b0, 1'b0};

  exp_t exp_q[$];
  exp_t exp_e;
  int   total = 0;
  int   bad   = 0;
  logic prev_busy = 1'b0;

  ioblock_cfg_loader #(
    .NUM_IOB   (N),
    .SYNC_WORD (8'hA5)
  ) dut (
    .IOCLK      (IOCLK),
    .RST        (RST),
    .CFG_EN     (CFG_EN),
    .CFG_DIN    (CFG_DIN),
    .TSMUX_CFG  (TSMUX_CFG),
    .DORREG_CFG (DORREG_CFG),
    .CFG_BUSY   (CFG_BUSY),
    .CFG_DONE   (CFG_DONE),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 IOCLK = ~IOCLK;

  // Monitor: every end of a frame (busy falling) pops one expected result.
  always @(negedge IOCLK) begin
    if (prev_busy && (CFG_BUSY !== 1'b1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_end: unexpected end of frame, got ts=%b dor=%b done=%b err=%b, required none",
                 TSMUX_CFG, DORREG_CFG, CFG_DONE, CFG_ERR);
      end else begin
        exp_e = exp_q.pop_front();
        if ({TSMUX_CFG, DORREG_CFG, CFG_DONE, CFG_ERR} !== exp_e) begin
          bad++;
          $display("FAIL frame_result: got ts=%b dor=%b done=%b err=%b, required ts=%b dor=%b done=%b err=%b",
                   TSMUX_CFG, DORREG_CFG, CFG_DONE, CFG_ERR,
                   exp_e.ts, exp_e.dor, exp_e.done, exp_e.err);
        end
      end
    end
    prev_busy <= (CFG_BUSY === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // One consumed bit, preceded by `gap` idle cycles carrying junk data.
  task automatic send_bit(input logic b, input int gap);
    CFG_EN = 1'b0;
    for (int g = 0; g < gap; g++) begin
      CFG_DIN = 1'($urandom);
      @(negedge IOCLK);
    end
    CFG_EN  = 1'b1;
    CFG_DIN = b;
    @(negedge IOCLK);
    CFG_EN  = 1'b0;
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(maxgap, 1)) : 0;
  endfunction

  task automatic send_sync(input int maxgap);
    logic [7:0] sw;
    sw = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(sw[i], pick_gap(maxgap));
  endtask

  task automatic send_frame(input logic [5:0] pay, input logic par, input int maxgap);
    send_sync(maxgap);
    for (int i = 5; i >= 0; i--) send_bit(pay[i], pick_gap(maxgap));
    check("busy_before_parity", 32'(CFG_BUSY), 32'd1);
    send_bit(par, pick_gap(maxgap));
  endtask

  initial begin
    logic [6:0] lead;
    RST     = 1'b1;
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
    repeat (2) @(negedge IOCLK);
    RST = 1'b0;
    @(negedge IOCLK);
    check("reset_tsmux",  32'(TSMUX_CFG),  32'd0);
    check("reset_dorreg", 32'(DORREG_CFG), 32'd0);
    check("reset_busy",   32'(CFG_BUSY),   32'd0);
    check("reset_done",   32'(CFG_DONE),   32'd0);
    check("reset_err",    32'(CFG_ERR),    32'd0);

    // Good frame, contiguous.
    exp_q.push_back(EXP_A);
    send_frame(PAY_A, 1'b1, 0);

    // Bad parity: outputs keep the previous commit.
    exp_q.push_back(EXP_A_BAD);
    send_frame(PAY_A, 1'b0, 0);

    // Gapped stream with a different payload.
    exp_q.push_back(EXP_B);
    send_frame(PAY_B, 1'b1, 5);

    // Back-to-back: sync begins on the bit right after the previous parity bit.
    exp_q.push_back(EXP_A);
    send_frame(PAY_A, 1'b1, 0);

    // Hunt robustness: partial sync prefix must not start a frame.
    lead = 7'b1010011;
    for (int i = 6; i >= 0; i--) send_bit(lead[i], 0);
    check("hunt_no_false_lock", 32'(CFG_BUSY), 32'd0);
    exp_q.push_back(EXP_B);
    send_frame(PAY_B, 1'b1, 0);
    check("hunt_tsmux", 32'(TSMUX_CFG), 32'h3);

    // Reset in the middle of LOAD after a prior commit.
    send_sync(0);
    for (int i = 5; i >= 3; i--) send_bit(PAY_A[i], 0);
    check("busy_mid_load", 32'(CFG_BUSY), 32'd1);
    exp_q.push_back(EXP_RST);
    RST = 1'b1;
    @(negedge IOCLK);
    RST = 1'b0;
    check("midload_rst_tsmux", 32'(TSMUX_CFG), 32'd0);
    check("midload_rst_done",  32'(CFG_DONE),  32'd0);

    // A full frame after the abort commits normally.
    exp_q.push_back(EXP_A);
    send_frame(PAY_A, 1'b1, 0);

    repeat (4) @(negedge IOCLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

endmodule
